// File: rtl/disp_scan_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multiplexed seven-segment display scanner:
//   HEX_SEG     nibble -> active-low segment pattern (a..g on bit6..bit0)
//   AN_OFF      all anodes off (active-low)
//   SEG_OFF     all segments off (active-low)
//   scan_state_t  scanner states SCAN / BLANK
//   upper_zero()  true when every nibble from digit d upward is zero
// -----------------------------------------------------------------------------
package disp_pkg;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  // True when word[31:4*d] is all zero, i.e. digit d and everything above it
  // would only show leading zeros.
  function automatic logic upper_zero(input logic [31:0] word, input logic [2:0] d);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << {d, 2'b00};
    return ((word & mask) == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/disp_scan_arbiter_rr_arb.sv
// -----------------------------------------------------------------------------
// disp_rr_arb
// Two-requester round-robin arbiter with a minimum-hold counter. Decisions are
// taken only when strobe (the frame boundary) is high.
// Ports:
//   clk        system clock
//   Rst_n      asynchronous active-low reset (grant returns to source 0)
//   strobe     frame-boundary pulse; arbitration happens only on this cycle
//   req[1:0]   level-sensitive requests from source 0 / source 1
//   grant      registered one-hot grant
//   grant_nxt  grant that will be registered at the coming edge, so the
//              scanner can latch the matching data word on the same edge
// -----------------------------------------------------------------------------
module disp_rr_arb
  import disp_pkg::*;
#(
  parameter int HOLD_FRAMES = 4
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       strobe,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic [1:0] grant_nxt
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic [1:0]    grant_r;
  logic [1:0]    grant_nxt_s;
  logic [HW-1:0] hold_r;
  logic [HW-1:0] hold_nxt_s;
  // Set from reset until the first boundary: reset counts as a fresh grant
  // whose first frame begins at that boundary, so it must not be pre-expired.
  logic          first_r;
  logic          cur_req_s;
  logic          oth_req_s;

  // Arbitration decision and hold-counter update for the next frame.
  always_comb begin
    grant_nxt_s = grant_r;
    hold_nxt_s  = hold_r;
    cur_req_s   = grant_r[1] ? req[1] : req[0];
    oth_req_s   = grant_r[1] ? req[0] : req[1];
    if (strobe) begin
      if (!cur_req_s && oth_req_s) begin
        grant_nxt_s = {grant_r[0], grant_r[1]};
        hold_nxt_s  = '0;
      end else if (!first_r && cur_req_s && oth_req_s && (hold_r >= HOLD_MAX)) begin
        grant_nxt_s = {grant_r[0], grant_r[1]};
        hold_nxt_s  = '0;
      end else if (first_r) begin
        hold_nxt_s  = '0;
      end else if (hold_r < HOLD_MAX) begin
        hold_nxt_s  = hold_r + HOLD_ONE;
      end else begin
        hold_nxt_s  = hold_r;
      end
    end else begin
      grant_nxt_s = grant_r;
      hold_nxt_s  = hold_r;
    end
  end

  // Grant, hold counter and first-boundary flag registers.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      grant_r <= 2'b01;
      hold_r  <= '0;
      first_r <= 1'b1;
    end else begin
      grant_r <= grant_nxt_s;
      hold_r  <= hold_nxt_s;
      if (strobe) begin
        first_r <= 1'b0;
      end
    end
  end

  assign grant     = grant_r;
  assign grant_nxt = grant_nxt_s;

endmodule

// File: rtl/disp_scan_arbiter.sv
// -----------------------------------------------------------------------------
// disp_scan_arbiter
// Scans an 8-digit multiplexed seven-segment display with inter-digit blanking
// and arbitrates it between two 32-bit hex sources. The displayed word is
// snapshotted once per frame so digits never tear.
// Build option: DISP_LEADING_ZERO_BLANK_EN - when defined, digits 1..7 whose
// nibble and all higher nibbles are zero are kept dark.
// Ports:
//   clk          system clock
//   Rst_n        asynchronous active-low reset
//   req[1:0]     per-source display request (level)
//   data0/data1  source words; nibble k goes to digit k
//   digit_en     per-digit enable, 0 keeps that anode off
//   an           anodes, active-low, one-hot-low or all ones
//   sev_out      segments a..g on bit6..bit0, active-low
//   grant        one-hot displayed source
//   frame_start  one-cycle pulse when digit 0 of a new frame lights
// -----------------------------------------------------------------------------
module disp_scan_arbiter
  import disp_pkg::*;
#(
  parameter int CLK_DIV     = 500,
  parameter int BLANK_CYC   = 8,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [7:0]  digit_en,
  output logic [7:0]  an,
  output logic [6:0]  sev_out,
  output logic [1:0]  grant,
  output logic        frame_start
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  scan_state_t   state_r, state_nxt_s;
  logic [2:0]    digit_r, digit_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [31:0]   frame_r, frame_nxt_s;
  logic [7:0]    an_r, an_nxt_s;
  logic [6:0]    sev_r, sev_nxt_s;
  logic          fs_r, fs_nxt_s;
  logic          enter_scan_s;
  logic          boundary_s;
  logic          show_s;
  logic [3:0]    nib_s;
  logic [1:0]    grant_nxt_s;

  // Frame-boundary arbiter: decides the source for the frame about to start.
  disp_rr_arb #(
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_arb (
    .clk       (clk),
    .Rst_n     (Rst_n),
    .strobe    (boundary_s),
    .req       (req),
    .grant     (grant),
    .grant_nxt (grant_nxt_s)
  );

  // Scan sequencer: SCAN for CLK_DIV cycles, BLANK for BLANK_CYC cycles.
  always_comb begin
    state_nxt_s  = state_r;
    digit_nxt_s  = digit_r;
    cnt_nxt_s    = cnt_r;
    enter_scan_s = 1'b0;
    case (state_r)
      SCAN: begin
        if (cnt_r == SCAN_LAST) begin
          cnt_nxt_s = '0;
          if (BLANK_CYC == 0) begin
            state_nxt_s  = SCAN;
            digit_nxt_s  = digit_r + 3'd1;
            enter_scan_s = 1'b1;
          end else begin
            state_nxt_s  = BLANK;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      BLANK: begin
        // With no blanking the only BLANK visit is the one left by reset.
        if ((BLANK_CYC == 0) || (cnt_r == BLANK_LAST)) begin
          cnt_nxt_s    = '0;
          state_nxt_s  = SCAN;
          digit_nxt_s  = digit_r + 3'd1;
          enter_scan_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = BLANK;
        digit_nxt_s = 3'd7;
        cnt_nxt_s   = '0;
      end
    endcase
    boundary_s = enter_scan_s && (digit_nxt_s == 3'd0);
  end

  // Next displayed pattern. an/sev are decided only on SCAN entry and then
  // held, so digit_en or data changes never cut a lit digit.
  always_comb begin
    frame_nxt_s = boundary_s ? (grant_nxt_s[1] ? data1 : data0) : frame_r;
    nib_s       = frame_nxt_s[{digit_nxt_s, 2'b00} +: 4];
`ifdef DISP_LEADING_ZERO_BLANK_EN
    show_s      = digit_en[digit_nxt_s] &&
                  ((digit_nxt_s == 3'd0) || !upper_zero(frame_nxt_s, digit_nxt_s));
`else
    show_s      = digit_en[digit_nxt_s];
`endif
    an_nxt_s    = an_r;
    sev_nxt_s   = sev_r;
    fs_nxt_s    = 1'b0;
    if (enter_scan_s) begin
      sev_nxt_s = HEX_SEG[nib_s];
      fs_nxt_s  = boundary_s;
      if (show_s) begin
        an_nxt_s = ~(8'b0000_0001 << digit_nxt_s);
      end else begin
        an_nxt_s = AN_OFF;
      end
    end else if (state_nxt_s == BLANK) begin
      an_nxt_s  = AN_OFF;
      sev_nxt_s = SEG_OFF;
    end else begin
      an_nxt_s  = an_r;
      sev_nxt_s = sev_r;
    end
  end

  // State, snapshot and registered output drive.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= BLANK;
      digit_r <= 3'd7;
      cnt_r   <= '0;
      frame_r <= 32'h0000_0000;
      an_r    <= AN_OFF;
      sev_r   <= SEG_OFF;
      fs_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      digit_r <= digit_nxt_s;
      cnt_r   <= cnt_nxt_s;
      frame_r <= frame_nxt_s;
      an_r    <= an_nxt_s;
      sev_r   <= sev_nxt_s;
      fs_r    <= fs_nxt_s;
    end
  end

  assign an          = an_r;
  assign sev_out     = sev_r;
  assign frame_start = fs_r;

endmodule
